// File: rtl/counter_slice_arbiter.sv
// Time-slice round-robin arbiter: owner keeps the resource until release or SLICE cycles, then hands off with no bubble.
// Latency 1 cycle req->grant, all outputs registered; no backpressure, requesters hold req level-high while waiting.
module counter_slice_arbiter #(
    parameter int N     = 4,
    parameter int SLICE = 16,
    parameter int IDW   = (N > 1) ? $clog2(N) : 1,
    parameter int SW    = (SLICE > 1) ? $clog2(SLICE) : 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [N-1:0]   i_req,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_grant_id,
    output logic           o_busy,
    output logic [SW-1:0]  o_slice_left,
    output logic           o_expire
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [SW-1:0]  COUNT_LAST = SW'(SLICE - 1);
    localparam logic [IDW-1:0] OWNER_LAST = IDW'(N - 1);

    logic [0:0]     r_state;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_owner;
    logic [SW-1:0]  r_count;

    logic [N-1:0]   r_grant;
    logic [IDW-1:0] r_grant_id;
    logic           r_busy;
    logic [SW-1:0]  r_slice_left;
    logic           r_expire;

    logic [0:0]     w_state_nxt;
    logic [IDW-1:0] w_ptr_nxt;
    logic [IDW-1:0] w_owner_nxt;
    logic [SW-1:0]  w_count_nxt;
    logic           w_expire_nxt;
    logic [N-1:0]   w_grant_nxt;

    logic [N-1:0]   w_owner_oh;
    logic [N-1:0]   w_others;
    logic           w_owner_req;
    logic [IDW-1:0] w_ptr_inc;
    logic [IDW-1:0] w_pick_idle;
    logic [IDW-1:0] w_pick_rel;
    logic [IDW-1:0] w_pick_exp;

    // First set bit of cand, scanning start, start+1, ... modulo N.
    function automatic logic [IDW-1:0] f_pick(input logic [N-1:0] cand, input logic [IDW-1:0] start);
        logic [IDW-1:0] sel;
        logic [IDW-1:0] idx;
        logic           found;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = IDW'((int'(start) + i) % N);
            if (!found && cand[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        return sel;
    endfunction

    always_comb begin
        w_owner_oh = '0;
        for (int i = 0; i < N; i++) begin
            w_owner_oh[i] = (r_owner == IDW'(i));
        end
    end

    assign w_others    = i_req & ~w_owner_oh;
    assign w_owner_req = |(i_req & w_owner_oh);
    assign w_ptr_inc   = (r_owner == OWNER_LAST) ? '0 : r_owner + 1'b1;
    assign w_pick_idle = f_pick(i_req, r_ptr);
    assign w_pick_rel  = f_pick(i_req, w_ptr_inc);
    assign w_pick_exp  = f_pick(w_others, w_ptr_inc);

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_owner_nxt  = r_owner;
        w_count_nxt  = r_count;
        w_expire_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|i_req) begin
                    w_state_nxt = ST_GRANT;
                    w_owner_nxt = w_pick_idle;
                    w_count_nxt = '0;
                end
            end
            default: begin
                // Release is checked first so it beats a simultaneous timeout.
                if (!w_owner_req) begin
                    w_ptr_nxt   = w_ptr_inc;
                    w_count_nxt = '0;
                    if (|i_req) begin
                        w_owner_nxt = w_pick_rel;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_owner_nxt = '0;
                    end
                end else if (r_count == COUNT_LAST) begin
                    w_expire_nxt = 1'b1;
                    w_ptr_nxt    = w_ptr_inc;
                    w_count_nxt  = '0;
                    if (|w_others) begin
                        w_owner_nxt = w_pick_exp;
                    end
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        w_grant_nxt = '0;
        for (int i = 0; i < N; i++) begin
            w_grant_nxt[i] = (w_state_nxt == ST_GRANT) && (w_owner_nxt == IDW'(i));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_owner      <= '0;
            r_count      <= '0;
            r_grant      <= '0;
            r_grant_id   <= '0;
            r_busy       <= 1'b0;
            r_slice_left <= '0;
            r_expire     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_owner      <= w_owner_nxt;
            r_count      <= w_count_nxt;
            r_grant      <= w_grant_nxt;
            r_grant_id   <= (w_state_nxt == ST_GRANT) ? w_owner_nxt : '0;
            r_busy       <= (w_state_nxt == ST_GRANT);
            r_slice_left <= (w_state_nxt == ST_GRANT) ? COUNT_LAST - w_count_nxt : '0;
            r_expire     <= w_expire_nxt;
        end
    end

    assign o_grant      = r_grant;
    assign o_grant_id   = r_grant_id;
    assign o_busy       = r_busy;
    assign o_slice_left = r_slice_left;
    assign o_expire     = r_expire;

endmodule

// File: tb/tb_counter_slice_arbiter.sv
// Two arbiter instances (N=4/SLICE=4 and N=1/SLICE=3) checked every cycle against a tenure-based model,
// plus literal expectations at the scenario milestones.
module tb_counter_slice_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req_a;
    logic [0:0] req_b;
    logic       chk_en;

    logic [3:0] a_grant;
    logic [1:0] a_id;
    logic       a_busy;
    logic [1:0] a_left;
    logic       a_exp;

    logic [0:0] b_grant;
    logic [0:0] b_id;
    logic       b_busy;
    logic [1:0] b_left;
    logic       b_exp;

    int n_pass  = 0;
    int n_total = 0;

    counter_slice_arbiter #(.N(4), .SLICE(4)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_req(req_a),
        .o_grant(a_grant), .o_grant_id(a_id), .o_busy(a_busy),
        .o_slice_left(a_left), .o_expire(a_exp)
    );

    counter_slice_arbiter #(.N(1), .SLICE(3)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_req(req_b),
        .o_grant(b_grant), .o_grant_id(b_id), .o_busy(b_busy),
        .o_slice_left(b_left), .o_expire(b_exp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // held = cycles the current owner has had the resource, including this one (1..slice).
    typedef struct packed {
        int busy;
        int owner;
        int ptr;
        int held;
        int expire;
    } mstate_t;

    mstate_t ma = '0;
    mstate_t mb = '0;

    function automatic int rr(input int req, input int start, input int n);
        for (int i = 0; i < n; i++) begin
            int j;
            j = (start + i) % n;
            if (((req >> j) & 1) != 0) return j;
        end
        return 0;
    endfunction

    function automatic mstate_t m_step(input mstate_t s, input int req, input int n, input int slice, input bit r);
        mstate_t t;
        int others;
        t = s;
        t.expire = 0;
        if (r) begin
            t = '0;
        end else if (s.busy == 0) begin
            if (req != 0) begin
                t.busy  = 1;
                t.owner = rr(req, s.ptr, n);
                t.held  = 1;
            end
        end else if (((req >> s.owner) & 1) == 0) begin
            t.ptr = (s.owner + 1) % n;
            if (req != 0) begin
                t.owner = rr(req, t.ptr, n);
                t.held  = 1;
            end else begin
                t.busy  = 0;
                t.owner = 0;
                t.held  = 0;
            end
        end else if (s.held == slice) begin
            t.expire = 1;
            t.ptr    = (s.owner + 1) % n;
            others   = req & ~(1 << s.owner);
            if (others != 0) t.owner = rr(others, t.ptr, n);
            t.held = 1;
        end else begin
            t.held = s.held + 1;
        end
        return t;
    endfunction

    always @(posedge clk) begin
        ma = m_step(ma, int'(req_a), 4, 4, rst);
        mb = m_step(mb, int'(req_b), 1, 3, rst);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_grant",  int'(a_grant), ma.busy != 0 ? (1 << ma.owner) : 0);
            chk("a_id",     int'(a_id),    ma.busy != 0 ? ma.owner : 0);
            chk("a_busy",   int'(a_busy),  ma.busy);
            chk("a_left",   int'(a_left),  ma.busy != 0 ? 4 - ma.held : 0);
            chk("a_expire", int'(a_exp),   ma.expire);
            chk("b_grant",  int'(b_grant), mb.busy);
            chk("b_id",     int'(b_id),    0);
            chk("b_busy",   int'(b_busy),  mb.busy);
            chk("b_left",   int'(b_left),  mb.busy != 0 ? 3 - mb.held : 0);
            chk("b_expire", int'(b_exp),   mb.expire);
        end
    end

    task automatic drive(input logic r, input logic [3:0] ra, input logic rb, input int n);
        rst   = r;
        req_a = ra;
        req_b = rb;
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst    = 1'b1;
        req_a  = '0;
        req_b  = '0;
        chk_en = 1'b0;
        @(posedge clk);
        #2;
        chk_en = 1'b1;

        drive(1'b1, 4'b0000, 1'b0, 2);
        chk("lit_rst_grant", int'(a_grant), 0);
        chk("lit_rst_busy",  int'(a_busy),  0);
        chk("lit_rst_left",  int'(a_left),  0);
        chk("lit_rst_b",     int'(b_grant), 0);

        drive(1'b0, 4'b0000, 1'b0, 5);
        chk("lit_idle_grant", int'(a_grant), 0);
        chk("lit_idle_exp",   int'(a_exp),   0);

        // Single requester 1 on A, sole requester on B.
        drive(1'b0, 4'b0010, 1'b1, 1);
        chk("lit_single_grant", int'(a_grant), 2);
        chk("lit_single_id",    int'(a_id),    1);
        chk("lit_single_left",  int'(a_left),  3);
        chk("lit_b_first_left", int'(b_left),  2);
        drive(1'b0, 4'b0010, 1'b1, 3);
        chk("lit_single_last_left", int'(a_left), 0);
        chk("lit_single_no_exp",    int'(a_exp),  0);
        chk("lit_b_exp",            int'(b_exp),  1);
        chk("lit_b_renew_left",     int'(b_left), 2);
        drive(1'b0, 4'b0010, 1'b1, 1);
        chk("lit_single_exp",   int'(a_exp),   1);
        chk("lit_single_renew", int'(a_grant), 2);
        chk("lit_single_left3", int'(a_left),  3);
        chk("lit_b_left1",      int'(b_left),  1);
        drive(1'b0, 4'b0010, 1'b1, 4);
        chk("lit_single_exp2",  int'(a_exp),   1);
        chk("lit_b_left0",      int'(b_left),  0);

        drive(1'b1, 4'b0010, 1'b1, 1);
        chk("lit_midrst_grant", int'(a_grant), 0);
        chk("lit_midrst_exp",   int'(a_exp),   0);
        chk("lit_midrst_b",     int'(b_grant), 0);

        // Full rotation with every requester pending.
        drive(1'b0, 4'b1111, 1'b0, 1);
        chk("lit_rot_g0", int'(a_grant), 1);
        drive(1'b0, 4'b1111, 1'b0, 4);
        chk("lit_rot_g1",   int'(a_grant), 2);
        chk("lit_rot_exp1", int'(a_exp),   1);
        drive(1'b0, 4'b1111, 1'b0, 4);
        chk("lit_rot_g2", int'(a_grant), 4);
        drive(1'b0, 4'b1111, 1'b0, 4);
        chk("lit_rot_g3",  int'(a_grant), 8);
        chk("lit_rot_id3", int'(a_id),    3);
        drive(1'b0, 4'b1111, 1'b0, 4);
        chk("lit_rot_wrap",   int'(a_grant), 1);
        chk("lit_rot_exp4",   int'(a_exp),   1);

        // Early release hands off without expire.
        drive(1'b1, 4'b0000, 1'b0, 1);
        drive(1'b0, 4'b0101, 1'b0, 2);
        chk("lit_rel_owner0", int'(a_grant), 1);
        chk("lit_rel_left2",  int'(a_left),  2);
        drive(1'b0, 4'b0100, 1'b0, 1);
        chk("lit_rel_grant", int'(a_grant), 4);
        chk("lit_rel_noexp", int'(a_exp),   0);
        chk("lit_rel_left",  int'(a_left),  3);

        // Release on the last slice cycle beats expiry, and wraps 3 -> 0.
        drive(1'b1, 4'b0000, 1'b0, 1);
        drive(1'b0, 4'b1000, 1'b0, 1);
        chk("lit_wrap_own3", int'(a_grant), 8);
        drive(1'b0, 4'b1001, 1'b0, 3);
        chk("lit_wrap_left0", int'(a_left),  0);
        chk("lit_wrap_still", int'(a_grant), 8);
        drive(1'b0, 4'b0001, 1'b0, 1);
        chk("lit_wrap_grant", int'(a_grant), 1);
        chk("lit_wrap_id",    int'(a_id),    0);
        chk("lit_wrap_noexp", int'(a_exp),   0);
        chk("lit_wrap_left",  int'(a_left),  3);

        drive(1'b0, 4'b0000, 1'b0, 1);
        chk("lit_idle2_grant", int'(a_grant), 0);
        chk("lit_idle2_busy",  int'(a_busy),  0);
        chk("lit_idle2_left",  int'(a_left),  0);

        drive(1'b0, 4'b0000, 1'b0, 2);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
